// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and helpers for the cache-line memory bus adapter.
// Holds the adapter state encoding and the beats-per-line helper.
package mem_bus_pkg;

  // Adapter transfer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Number of memory beats in one cache line.
  function automatic int unsigned beats_per_line(input int unsigned offset_length);
    return 32'd1 << offset_length;
  endfunction

endpackage

// File: rtl/mem_bus_adapter_beat_counter.sv
// beat_counter: beat index for one line transfer.
// The index is loaded with the starting word, advances by one per accepted
// beat and wraps modulo the line size. The last-beat flag is raised on the
// beat whose successor index would return to the starting word, so a
// transfer is always exactly one full line regardless of where it started.
module beat_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] idx_o,
  output logic             last_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] idx_q;
  logic [CNT_W-1:0] idx_d;
  logic [CNT_W-1:0] start_q;
  logic [CNT_W-1:0] start_d;
  logic [CNT_W-1:0] idx_inc;

  // Natural-width addition wraps modulo the line size.
  assign idx_inc = idx_q + ONE;

  // Next-state selection: load has priority over increment.
  always_comb begin
    idx_d   = idx_q;
    start_d = start_q;
    if (load_i) begin
      idx_d   = load_val_i;
      start_d = load_val_i;
    end else if (inc_i) begin
      idx_d = idx_inc;
    end
  end

  // Counter and start-word registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= '0;
      start_q <= '0;
    end else begin
      idx_q   <= idx_d;
      start_q <= start_d;
    end
  end

  assign idx_o  = idx_q;
  assign last_o = (idx_inc == start_q);

endmodule

// File: rtl/mem_bus_adapter.sv
// mem_bus_adapter: moves whole cache lines between a cache-side command
// port and a beat-oriented memory bus (request, write-beat and read-beat
// channels). One transfer is in flight at a time.
// Optional feature: define MEM_ADAPTER_CRIT_WORD_FIRST_EN to start fills at
// the requested word (critical word first); write-backs always start at 0.
module mem_bus_adapter
  import mem_bus_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 64,
  parameter int OFFSET_LENGTH = 5
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      command_valid,
  input  logic                                      command_store,
  input  logic [ADDR_WIDTH-1:0]                     command_addr,
  input  logic [DATA_WIDTH*(2**OFFSET_LENGTH)-1:0]  data_to_bus,
  output logic                                      bus_ready,
  output logic                                      bus_valid,
  output logic [DATA_WIDTH*(2**OFFSET_LENGTH)-1:0]  line_from_bus,
  output logic                                      mem_req_valid,
  input  logic                                      mem_req_ready,
  output logic                                      mem_req_store,
  output logic [ADDR_WIDTH-1:0]                     mem_req_addr,
  output logic                                      mem_wvalid,
  input  logic                                      mem_wready,
  output logic [DATA_WIDTH-1:0]                     mem_wdata,
  input  logic                                      mem_rvalid,
  output logic                                      mem_rready,
  input  logic [DATA_WIDTH-1:0]                     mem_rdata
);

  localparam int WORDS  = int'(beats_per_line(OFFSET_LENGTH));
  localparam int LINE_W = DATA_WIDTH * WORDS;

  state_t                     state_q;
  state_t                     state_d;
  logic                       store_q;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [LINE_W-1:0]          wline_q;

  logic                       accept;
  logic                       cnt_inc;
  logic                       rd_we;
  logic [OFFSET_LENGTH-1:0]   start_word;
  logic [OFFSET_LENGTH-1:0]   beat_idx;
  logic                       beat_last;
  logic [ADDR_WIDTH-1:0]      aligned_addr;

  assign aligned_addr = {addr_q[ADDR_WIDTH-1:OFFSET_LENGTH], {OFFSET_LENGTH{1'b0}}};

`ifdef MEM_ADAPTER_CRIT_WORD_FIRST_EN
  // Fills begin at the requested word; write-backs still stream from word 0.
  assign start_word   = command_store ? '0 : command_addr[OFFSET_LENGTH-1:0];
  assign mem_req_addr = store_q ? aligned_addr : addr_q;
`else
  // Every transfer streams the line from word 0.
  assign start_word   = '0;
  assign mem_req_addr = aligned_addr;
  logic unused_offset_bits;
  assign unused_offset_bits = &{1'b0, addr_q[OFFSET_LENGTH-1:0]};
`endif

  beat_counter #(
    .CNT_W (OFFSET_LENGTH)
  ) u_beat_counter (
    .clk        (clk),
    .reset      (reset),
    .load_i     (accept),
    .load_val_i (start_word),
    .inc_i      (cnt_inc),
    .idx_o      (beat_idx),
    .last_o     (beat_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and per-state channel strobes.
  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    cnt_inc       = 1'b0;
    rd_we         = 1'b0;
    bus_ready     = 1'b0;
    bus_valid     = 1'b0;
    mem_req_valid = 1'b0;
    mem_wvalid    = 1'b0;
    mem_rready    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus_ready = 1'b1;
        if (command_valid) begin
          accept  = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = store_q ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        mem_wvalid = 1'b1;
        if (mem_wready) begin
          cnt_inc = 1'b1;
          if (beat_last) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_READ: begin
        mem_rready = 1'b1;
        if (mem_rvalid) begin
          rd_we   = 1'b1;
          cnt_inc = 1'b1;
          if (beat_last) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        bus_valid = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Command latches, captured only when a command is accepted in IDLE so the
  // request fields and write-back data stay stable for the whole transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      store_q <= 1'b0;
      addr_q  <= '0;
      wline_q <= '0;
    end else if (accept) begin
      store_q <= command_store;
      addr_q  <= command_addr;
      wline_q <= data_to_bus;
    end
  end

  assign mem_req_store = store_q;
  assign mem_wdata     = wline_q[beat_idx*DATA_WIDTH +: DATA_WIDTH];

  // Fill line buffer: one register per word, written only by read beats, so a
  // write-back leaves the last completed fill visible on line_from_bus.
  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_word
      localparam logic [OFFSET_LENGTH-1:0] WORD_IDX = OFFSET_LENGTH'(gi);
      logic [DATA_WIDTH-1:0] word_q;

      // Capture the read beat addressed to this word.
      always_ff @(posedge clk) begin
        if (reset) begin
          word_q <= '0;
        end else if (rd_we && (beat_idx == WORD_IDX)) begin
          word_q <= mem_rdata;
        end
      end

      assign line_from_bus[gi*DATA_WIDTH +: DATA_WIDTH] = word_q;
    end
  endgenerate

endmodule

// File: tb/tb_mem_bus_adapter.sv
// Directed testbench for mem_bus_adapter (DATA_WIDTH=16, ADDR_WIDTH=16,
// OFFSET_LENGTH=2). Expected lines, beats and addresses are queued when a
// command is issued and popped when the adapter produces them.
module tb_mem_bus_adapter;

  localparam int DW     = 16;
  localparam int AW     = 16;
  localparam int OL     = 2;
  localparam int WORDS  = 4;
  localparam int LINE_W = DW * WORDS;

  logic              clk = 1'b0;
  logic              reset;
  logic              command_valid;
  logic              command_store;
  logic [AW-1:0]     command_addr;
  logic [LINE_W-1:0] data_to_bus;
  logic              bus_ready;
  logic              bus_valid;
  logic [LINE_W-1:0] line_from_bus;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_store;
  logic [AW-1:0]     mem_req_addr;
  logic              mem_wvalid;
  logic              mem_wready;
  logic [DW-1:0]     mem_wdata;
  logic              mem_rvalid;
  logic              mem_rready;
  logic [DW-1:0]     mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [LINE_W-1:0] exp_line_q[$];
  logic [DW-1:0]     exp_word_q[$];
  logic [AW-1:0]     exp_addr_q[$];
  logic [LINE_W-1:0] last_fill_line;

  mem_bus_adapter #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .OFFSET_LENGTH (OL)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .command_valid (command_valid),
    .command_store (command_store),
    .command_addr  (command_addr),
    .data_to_bus   (data_to_bus),
    .bus_ready     (bus_ready),
    .bus_valid     (bus_valid),
    .line_from_bus (line_from_bus),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_store (mem_req_store),
    .mem_req_addr  (mem_req_addr),
    .mem_wvalid    (mem_wvalid),
    .mem_wready    (mem_wready),
    .mem_wdata     (mem_wdata),
    .mem_rvalid    (mem_rvalid),
    .mem_rready    (mem_rready),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Fill a line; memory answers with base, base+1, ... in beat order.
  // With hold_cmd the command stays asserted and is left asserted on return.
  task automatic do_fill(input logic [AW-1:0] addr, input logic [DW-1:0] base,
                         input bit hold_cmd, input bit zero_wait);
    int start;
    int k;
    int cyc;
    int valids;
    int reqs;
    logic [LINE_W-1:0] line;
    logic [DW-1:0]     wd;
`ifdef MEM_ADAPTER_CRIT_WORD_FIRST_EN
    start = int'(addr[OL-1:0]);
    exp_addr_q.push_back(addr);
`else
    start = 0;
    exp_addr_q.push_back({addr[AW-1:OL], {OL{1'b0}}});
`endif
    line = '0;
    for (int i = 0; i < WORDS; i++) begin
      wd = base + DW'(i);
      line[((start + i) % WORDS)*DW +: DW] = wd;
    end
    exp_line_q.push_back(line);
    command_valid = 1'b1;
    command_store = 1'b0;
    command_addr  = addr;
    check("fill_bus_ready_idle", 64'(bus_ready), 64'd1);
    tick();
    if (!hold_cmd) command_valid = 1'b0;
    cyc = 0; k = 0; valids = 0; reqs = 0;
    while (valids == 0 && cyc < 100) begin
      cyc++;
      mem_req_ready = mem_req_valid;
      if (mem_req_valid) begin
        reqs++;
        check("fill_req_addr", 64'(mem_req_addr), 64'(exp_addr_q.pop_front()));
        check("fill_req_store", 64'(mem_req_store), 64'd0);
      end
      if (hold_cmd) check("hold_bus_ready_busy", 64'(bus_ready), 64'd0);
      check("fill_no_wvalid", 64'(mem_wvalid), 64'd0);
      if (mem_rready) begin
        mem_rvalid = 1'b1;
        mem_rdata  = base + DW'(k);
        k++;
      end else begin
        mem_rvalid = 1'b0;
      end
      if (bus_valid) begin
        valids++;
        check("fill_line", 64'(line_from_bus), 64'(exp_line_q.pop_front()));
        check("fill_beats", 64'(k), 64'd4);
        if (zero_wait) check("fill_latency", 64'(cyc), 64'd6);
      end
      tick();
    end
    if (valids == 0) check("fill_timeout", 64'd0, 64'd1);
    mem_req_ready = 1'b0;
    mem_rvalid    = 1'b0;
    last_fill_line = line;
    check("fill_single_pulse", 64'(bus_valid), 64'd0);
    check("fill_idle_ready", 64'(bus_ready), 64'd1);
    if (hold_cmd) check("hold_one_request", 64'(reqs), 64'd1);
    $display("fill addr=0x%0h start=%0d line=0x%0h cycles=%0d", addr, start, line, cyc);
  endtask

  // Write back a line; the memory withholds mem_wready for stall_n cycles
  // when beat stall_beat is first presented.
  task automatic do_wb(input logic [AW-1:0] addr, input logic [LINE_W-1:0] line,
                       input int stall_beat, input int stall_n);
    int cyc;
    int beats;
    int valids;
    int stall_left;
    for (int i = 0; i < WORDS; i++) exp_word_q.push_back(line[i*DW +: DW]);
    exp_addr_q.push_back({addr[AW-1:OL], {OL{1'b0}}});
    command_valid = 1'b1;
    command_store = 1'b1;
    command_addr  = addr;
    data_to_bus   = line;
    check("wb_bus_ready_idle", 64'(bus_ready), 64'd1);
    tick();
    command_valid = 1'b0;
    data_to_bus   = {WORDS{16'hDEAD}};
    cyc = 0; beats = 0; valids = 0; stall_left = stall_n;
    while (valids == 0 && cyc < 100) begin
      cyc++;
      mem_req_ready = mem_req_valid;
      if (mem_req_valid) begin
        check("wb_req_addr", 64'(mem_req_addr), 64'(exp_addr_q.pop_front()));
        check("wb_req_store", 64'(mem_req_store), 64'd1);
      end
      check("wb_no_rready", 64'(mem_rready), 64'd0);
      if (mem_wvalid) begin
        if (beats == stall_beat && stall_left > 0) begin
          mem_wready = 1'b0;
          check("wb_hold_data", 64'(mem_wdata), 64'(exp_word_q[0]));
          stall_left--;
        end else begin
          mem_wready = 1'b1;
          check("wb_beat_data", 64'(mem_wdata), 64'(exp_word_q.pop_front()));
          beats++;
        end
      end else begin
        mem_wready = 1'b0;
      end
      if (bus_valid) begin
        valids++;
        check("wb_beats", 64'(beats), 64'd4);
        check("wb_line_kept", 64'(line_from_bus), 64'(last_fill_line));
      end
      tick();
    end
    if (valids == 0) check("wb_timeout", 64'd0, 64'd1);
    mem_req_ready = 1'b0;
    mem_wready    = 1'b0;
    check("wb_single_pulse", 64'(bus_valid), 64'd0);
    check("wb_words_drained", 64'(exp_word_q.size()), 64'd0);
    $display("writeback addr=0x%0h line=0x%0h beats=%0d cycles=%0d", addr, line, beats, cyc);
  endtask

  initial begin
    reset = 1'b1;
    command_valid = 1'b0; command_store = 1'b0; command_addr = '0; data_to_bus = '0;
    mem_req_ready = 1'b0; mem_wready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    last_fill_line = '0;
    tick();
    tick();
    check("rst_bus_ready", 64'(bus_ready), 64'd1);
    check("rst_bus_valid", 64'(bus_valid), 64'd0);
    check("rst_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_wvalid", 64'(mem_wvalid), 64'd0);
    check("rst_rready", 64'(mem_rready), 64'd0);
    check("rst_line", 64'(line_from_bus), 64'd0);
    check("rst_req_addr", 64'(mem_req_addr), 64'd0);
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    $display("reset state checked");
    reset = 1'b0;
    tick();

    do_fill(16'h0107, 16'h00A0, 1'b0, 1'b1);
    do_wb(16'h0123, {16'd4, 16'd3, 16'd2, 16'd1}, 2, 3);
    do_fill(16'h0106, 16'h00B0, 1'b0, 1'b1);
    do_wb(16'h0340, {16'h0044, 16'h0033, 16'h0022, 16'h0011}, 0, 1);

    // Command held high: the second command is taken in the IDLE cycle after DONE.
    do_fill(16'h0200, 16'h00C0, 1'b1, 1'b1);
    tick();
    check("hold_second_accepted", 64'(mem_req_valid), 64'd1);
    check("hold_second_busy", 64'(bus_ready), 64'd0);
    command_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("abort_in_read", 64'(mem_rready), 64'd1);
    mem_rvalid = 1'b1;
    mem_rdata  = 16'h0F0F;
    tick();
    // Reset during read beat 1.
    mem_rvalid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_bus_ready", 64'(bus_ready), 64'd1);
    check("abort_line_cleared", 64'(line_from_bus), 64'd0);
    check("abort_no_valid", 64'(bus_valid), 64'd0);
    check("abort_no_rready", 64'(mem_rready), 64'd0);
    last_fill_line = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_quiet", 64'(bus_valid), 64'd0);
    end
    $display("reset during read checked");

    do_wb(16'h0400, {16'h8888, 16'h7777, 16'h6666, 16'h5555}, 3, 2);
    do_fill(16'h0501, 16'h00D0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
